// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, fetches one instruction per step over a
// req/ack handshake and issues it to the core over a valid/ready handshake.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retire;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_boff_bytes;
  logic [31:0] w_next_pc;

  assign w_pc_plus4   = r_pc + 32'd4;
  // Branch offset is in words; scale to bytes, wrapping modulo 2^32.
  assign w_boff_bytes = branch_offset << 2;
  assign w_next_pc    = branch_taken ? (w_pc_plus4 + w_boff_bytes) : w_pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_retire <= '0;
    end else begin
      case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            r_pc     <= w_next_pc;
            r_retire <= r_retire + 32'd1;
            r_state  <= FETCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_req     = (r_state == FETCH);
  assign imem_addr    = r_pc;
  assign instr_valid  = (r_state == ISSUE);
  assign instr        = r_instr;
  assign op           = r_instr[31:26];
  assign funct        = r_instr[5:0];
  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign retire_count = r_retire;

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-cycle MIPS core. Holds the program counter, fetches one 32-bit instruction per step from instruction memory over a request/acknowledge handshake, and presents it with `op`/`funct` to the control unit and datapath through a valid/ready handshake. On each consumed instruction it computes the next PC: sequential, or branch target when the datapath reports a taken `beq`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; word-aligned.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of fetch; equals `pc`.
- `imem_ack`  in  1  memory acknowledge; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  registered instruction for the core.
- `op`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `pc`  out  32  address of the instruction in `instr`.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `instr_valid`  out  1  `instr`/`op`/`funct`/`pc` are valid.
- `instr_ready`  in  1  core consumes the current instruction this cycle.
- `branch_taken`  in  1  `branch & zero` from the datapath; sampled only on consume.
- `branch_offset`  in  32  sign-extended 16-bit immediate (word offset).
- `retire_count`  out  32  number of instructions consumed since reset, modulo 2^32.

## Operation
- States: IDLE, FETCH, ISSUE.
- IDLE: entered on reset; `imem_req=0`, `instr_valid=0`. Next cycle unconditionally → FETCH.
- FETCH: `imem_req=1`, `imem_addr=pc`, stable until ack. On `imem_ack=1`: `instr <= imem_rdata`, → ISSUE. No ack → remain, request held.
- ISSUE: `imem_req=0`, `instr_valid=1`, outputs held stable. On `instr_ready=1`: `pc <= branch_taken ? pc_plus4 + (branch_offset << 2) : pc_plus4`, `retire_count <= retire_count + 1`, → FETCH. No ready → remain.
- Next-PC arithmetic: 32-bit, modulo 2^32; bits [1:0] of `pc` always 0.
- `imem_ack` in IDLE or ISSUE: ignored, no state change.
- `instr_ready`, `branch_taken`, `branch_offset` outside ISSUE: ignored.
- `op`, `funct` combinationally sliced from registered `instr`; `pc_plus4` combinational from `pc`.

## Timing
- Reset values: state IDLE, `pc=RESET_PC`, `instr=0` (so `op=0`, `funct=0`), `imem_req=0`, `instr_valid=0`, `retire_count=0`, `pc_plus4=RESET_PC+4`.
- Reset dominates every other input in the same cycle; reset mid-FETCH abandons the request (req drops next edge), a late ack is ignored.
- First request: cycle after reset deasserts is IDLE, following cycle `imem_req=1`.
- Fetch latency: `instr_valid` rises the cycle after the ack edge.
- Best-case throughput: one instruction per 2 cycles (ack in first FETCH cycle, ready in first ISSUE cycle); FETCH after consume addresses the new `pc` with no idle cycle.
- `pc` updates on the consume edge; `imem_addr` shows new PC in the same cycle `imem_req` reasserts.
- Wrap-around: `pc=32'hFFFF_FFFC` sequential → `32'h0000_0000`; `retire_count` wraps 32'hFFFF_FFFF → 0.

## Test plan
- Reset then memory acking immediately, `instr_ready=1`, no branches → `imem_addr` sequence 0x0,0x4,0x8; `instr_valid` pulses every 2nd cycle; `retire_count=3` after three consumes.
- Ack delayed 3 cycles at addr 0x10 → `imem_req` and `imem_addr=0x10` stable for 4 cycles; `instr_valid` low throughout, high the cycle after ack.
- `instr_ready` held low 5 cycles in ISSUE with `imem_ack` toggling → `instr`, `pc`, `op`, `funct` unchanged, `imem_req=0`, no PC change.
- `beq` at `pc=0x20`, `branch_taken=1`, `branch_offset=32'hFFFF_FFFE` → next `imem_addr=0x1C`; offset `0x3` → `0x30`; `branch_taken=0` → `0x24`.
- `RESET_PC=32'hFFFF_FFFC`, consume one sequential instruction → next fetch at `0x0`; `imem_rdata=32'h0000_002A` → `op=0`, `funct=6'h2A`.
- Assert `reset` mid-FETCH with ack arriving the same and following cycle → state IDLE, `pc=RESET_PC`, `instr_valid=0`, `retire_count=0`, ack ignored.
